// File: rtl/puf_key_reader.sv
// puf_key_reader: majority-votes NVOTES PUF evaluations into a stable key,
// flags bits that flipped between evaluations, and checks the voted key
// against an enrolled key within a Hamming-distance threshold.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; results from the last read are held
// S_COLLECT | accumulating per-bit one counts on each resp_valid strobe
// S_DECIDE  | one cycle: vote, stability, distance and match registered
// S_DONE    | one cycle: done pulse, results valid
module puf_key_reader #(
  parameter  int NBITS   = 8,
  parameter  int NVOTES  = 7,
  parameter  int TIMEOUT = 1024,
  localparam int CW      = $clog2(NVOTES + 1),
  localparam int HW      = $clog2(NBITS + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [NBITS-1:0] resp,
  input  logic [NBITS-1:0] enroll_key,
  input  logic [HW-1:0]    hd_thresh,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] key,
  output logic [NBITS-1:0] unstable,
  output logic [HW-1:0]    hd,
  output logic             match,
  output logic             timeout_err
);

  // Watchdog counts down from TIMEOUT-2; hitting zero on a strobe-less
  // cycle means TIMEOUT-1 consecutive idle cycles have elapsed.
  localparam int            WW        = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;
  localparam logic [WW-1:0] WDOG_LOAD = WW'(TIMEOUT - 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(NVOTES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(NVOTES);
  localparam logic [CW-1:0] HALF_CNT  = CW'(NVOTES / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     ones [NBITS];
  logic [CW-1:0]     scnt;
  logic [WW-1:0]     wdog;
  logic              last_sample;
  logic              wdog_expired;
  logic [NBITS-1:0]  key_nx;
  logic [NBITS-1:0]  unstable_nx;
  logic [HW-1:0]     hd_nx;
  logic              match_nx;

  assign last_sample  = (scnt == LAST_CNT);
  assign wdog_expired = (wdog == '0);

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        busy = 1'b1;
        if (resp_valid) begin
          if (last_sample) state_nx = S_DECIDE;
        end else if (wdog_expired) begin
          state_nx = S_DONE;
        end
      end
      S_DECIDE: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Vote, stability flags, Hamming distance and threshold compare.
  always_comb begin
    key_nx      = '0;
    unstable_nx = '0;
    hd_nx       = '0;
    for (int i = 0; i < NBITS; i++) begin
      key_nx[i]      = (ones[i] > HALF_CNT);
      unstable_nx[i] = (ones[i] != '0) && (ones[i] != FULL_CNT);
    end
    for (int i = 0; i < NBITS; i++) begin
      hd_nx = hd_nx + HW'(key_nx[i] ^ enroll_key[i]);
    end
    match_nx = (hd_nx <= hd_thresh);
  end

  // Sample counters, watchdog and result registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NBITS; i++) ones[i] <= '0;
      scnt        <= '0;
      wdog        <= '0;
      key         <= '0;
      unstable    <= '0;
      hd          <= '0;
      match       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NBITS; i++) ones[i] <= '0;
            scnt        <= '0;
            wdog        <= WDOG_LOAD;
            timeout_err <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (resp_valid) begin
            for (int i = 0; i < NBITS; i++) ones[i] <= ones[i] + CW'(resp[i]);
            scnt <= scnt + CW'(1);
            wdog <= WDOG_LOAD;
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
            key         <= '0;
            unstable    <= '0;
            hd          <= '0;
            match       <= 1'b0;
          end else begin
            wdog <= wdog - WW'(1);
          end
        end
        S_DECIDE: begin
          key      <= key_nx;
          unstable <= unstable_nx;
          hd       <= hd_nx;
          match    <= match_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_reader.sv
// Directed bench for puf_key_reader (NBITS=8, NVOTES=7, TIMEOUT=16).
module tb_puf_key_reader;

  logic       Clk;
  logic       Rst_n;
  logic       start;
  logic       resp_valid;
  logic [7:0] resp;
  logic [7:0] enroll_key;
  logic [3:0] hd_thresh;
  logic       busy;
  logic       done;
  logic [7:0] key;
  logic [7:0] unstable;
  logic [3:0] hd;
  logic       match;
  logic       timeout_err;

  int passes = 0;
  int total  = 0;

  puf_key_reader #(.NBITS(8), .NVOTES(7), .TIMEOUT(16)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .start       (start),
    .resp_valid  (resp_valid),
    .resp        (resp),
    .enroll_key  (enroll_key),
    .hd_thresh   (hd_thresh),
    .busy        (busy),
    .done        (done),
    .key         (key),
    .unstable    (unstable),
    .hd          (hd),
    .match       (match),
    .timeout_err (timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] k, input logic [7:0] u,
                         input logic [3:0] h, input logic m, input logic te);
    chk({tag, ".key"},         32'(key),         32'(k));
    chk({tag, ".unstable"},    32'(unstable),    32'(u));
    chk({tag, ".hd"},          32'(hd),          32'(h));
    chk({tag, ".match"},       32'(match),       32'(m));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
  endtask

  task automatic strobe(input logic [7:0] v);
    resp_valid = 1'b1;
    resp       = v;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full read: start, seven back-to-back strobes (byte i of vs is strobe i),
  // done must appear exactly two cycles after the last strobe.
  task automatic read7(input string tag, input logic [55:0] vs);
    pulse_start();
    chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      strobe(vs[8*i +: 8]);
      chk({tag, ".no_early_done"}, 32'(done), 32'd0);
    end
    chk({tag, ".busy_in_decide"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    Rst_n      = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp       = 8'h00;
    enroll_key = 8'h00;
    hd_thresh  = 4'd0;
    tick();
    tick();
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk_res("reset", 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    Rst_n = 1'b1;
    tick();

    // All-ones vote
    enroll_key = 8'hFF;
    hd_thresh  = 4'd0;
    read7("t1", 56'hFF_FF_FF_FF_FF_FF_FF);
    chk_res("t1", 8'hFF, 8'h00, 4'd0, 1'b1, 1'b0);
    tick();
    chk("t1.done_one_cycle", 32'(done), 32'd0);
    chk("t1.key_held", 32'(key), 32'hFF);

    // Strobes in IDLE must not count; start mid-collect must not restart
    strobe(8'hFF);
    strobe(8'hFF);
    chk("t6.idle_strobe_busy", 32'(busy), 32'd0);
    enroll_key = 8'hA5;
    pulse_start();
    strobe(8'hA5);
    tick();
    strobe(8'h5A);
    pulse_start();
    strobe(8'hA5);
    strobe(8'h5A);
    tick();
    strobe(8'hA5);
    strobe(8'h5A);
    chk("t6.still_busy", 32'(busy), 32'd1);
    chk("t6.no_done_yet", 32'(done), 32'd0);
    strobe(8'hA5);
    chk("t2.decide", 32'(done), 32'd0);
    tick();
    chk("t2.done", 32'(done), 32'd1);
    chk_res("t2", 8'hA5, 8'hFF, 4'd0, 1'b1, 1'b0);
    tick();

    // Threshold boundary: key 0F vs enrolled 03 -> distance 2
    enroll_key = 8'h03;
    hd_thresh  = 4'd1;
    read7("t3a", 56'h0F_0F_0F_0F_0F_0F_0F);
    chk_res("t3a", 8'h0F, 8'h00, 4'd2, 1'b0, 1'b0);
    tick();
    hd_thresh = 4'd2;
    read7("t3b", 56'h00_00_00_0F_0F_0F_0F);
    chk_res("t3b", 8'h0F, 8'h0F, 4'd2, 1'b1, 1'b0);
    tick();

    // Timeout after 3 strobes: done after TIMEOUT-1 idle cycles
    pulse_start();
    strobe(8'h11);
    strobe(8'h11);
    strobe(8'h11);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("t4.idle_cycles_to_done", 32'(n), 32'd15);
    chk("t4.busy", 32'(busy), 32'd0);
    chk_res("t4", 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    tick();
    chk("t4.terr_held", 32'(timeout_err), 32'd1);
    enroll_key = 8'h3C;
    pulse_start();
    chk("t4.start_clears_terr", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 7; i++) strobe(8'h3C);
    tick();
    chk("t4.recover_done", 32'(done), 32'd1);
    chk_res("t4r", 8'h3C, 8'h00, 4'd0, 1'b1, 1'b0);
    tick();

    // Reset mid-collect, then a fresh read must need all seven strobes
    pulse_start();
    for (int i = 0; i < 4; i++) strobe(8'hFF);
    Rst_n = 1'b0;
    tick();
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.done", 32'(done), 32'd0);
    chk_res("t5", 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    Rst_n = 1'b1;
    read7("t5r", 56'h00_00_00_00_FF_FF_FF);
    chk_res("t5r", 8'h00, 8'hFF, 4'd4, 1'b0, 1'b0);
    tick();
    chk("t5r.idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
